bram32_lsu_adapter: RTL and testbench
=====================================

// Module: bram32_lsu_adapter
// PURPOSE
//  Load/store adapter between the CPU data-memory port and a 32-bit word BRAM (1-cycle registered read, 3-bit write subaddress).
//  Converts byte addresses + access size into word address/write-subaddress, extracts & sign/zero-extends load data,
//  flags misaligned/out-of-range accesses. Single outstanding request; valid/ready on request and response sides.
// PARAMETERS
//  DEPTH       512               BRAM depth in 32-bit words; must match the attached BRAM
//  ADDR_WIDTH  $clog2(DEPTH)     localparam; BRAM word-address width
// PORTS
//  i_clk             in   1           clock, rising edge
//  i_rst             in   1           reset, asynchronous, active-high
//  i_req_valid       in   1           request valid
//  o_req_ready       out  1           request ready
//  i_req_addr        in   32          byte address
//  i_req_we          in   1           1 = store, 0 = load
//  i_req_size        in   2           0 = byte, 1 = half, 2 = word, 3 = illegal
//  i_req_unsigned    in   1           load zero-extends when 1, sign-extends when 0
//  i_req_wdata       in   32          store data, right-justified (byte in [7:0], half in [15:0])
//  o_rsp_valid       out  1           response valid
//  i_rsp_ready       in   1           response ready
//  o_rsp_rdata       out  32          extended load data; 0 for stores and errors
//  o_rsp_err         out  1           access faulted; no memory side effect
//  o_mem_addr        out  ADDR_WIDTH  BRAM word address = i_req_addr[ADDR_WIDTH+1:2]
//  o_mem_wdata       out  32          = i_req_wdata (BRAM takes low lanes per subaddress)
//  o_mem_we          out  1           BRAM write enable
//  o_mem_wr_subaddr  out  3           1 = word; 2/3 = half0/half1; 4..7 = byte0..byte3
//  i_mem_rdata       in   32          BRAM read data, valid 1 cycle after address
// BEHAVIOUR
//  - FSM states: IDLE, RD_WAIT, RESP. Reset (async) -> IDLE, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
//  - o_req_ready = (state==IDLE) | (state==RESP & i_rsp_ready). This is a combinational path from i_rsp_ready; intended.
//  - accept = i_req_valid & o_req_ready.
//  - err = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (addr[31:ADDR_WIDTH+2]!=0).
//  - o_mem_addr and o_mem_wdata are driven combinationally from the request at all times.
//  - o_mem_we = accept & we & ~err (combinational).
//  - o_mem_wr_subaddr: word -> 1; half -> 2+addr[1]; byte -> 4+addr[1:0]; 0 when o_mem_we=0.
//  - Store (or any err) accepted at edge E0: memory write commits at E0.
//    RESP from E0: rsp_valid=1, rdata=0, err as computed.
//  - Load, no err, accepted at E0: latch size/unsigned/addr[1:0]; go to RD_WAIT.
//    At E1, format i_mem_rdata into o_rsp_rdata; go to RESP with rsp_valid=1.
//    Load-to-response latency: 2 edges.
//  - Load format: word -> rdata. Half -> rdata[16*off[1] +:16]. Byte -> rdata[8*off +:8].
//    Extend to 32 bits with bit 15/7 (signed) or 0 (unsigned).
//  - RESP: o_rsp_rdata/o_rsp_err held stable while i_rsp_ready=0.
//    On i_rsp_ready: go to IDLE; if a new request is accepted on the same edge, go directly to its next state (back-to-back).
//  - RD_WAIT ignores i_rsp_ready and requests (o_req_ready=0).
//  - Reset mid-operation: in-flight load is dropped, no response. A store already past its accept edge stays written.
//  - Peak throughput: 1 store/cycle with i_rsp_ready held 1; 1 load per 2 cycles.
// TESTING
//  1. Store word 0xDEADBEEF @0x10; load byte signed @0x13 -> rdata 0xFFFFFFDE, err 0, rsp_valid 2 edges after accept.
//  2. Load half unsigned @0x12 -> 0x0000DEAD; load half signed @0x10 -> 0xFFFFBEEF.
//  3. Store byte 0x5A @0x11 (subaddr 5), then load word @0x10 -> 0xDEAD5AEF.
//  4. Store word @0x02 (misaligned) and load word @0x800 (DEPTH=512) -> err=1, rdata 0, o_mem_we never 1, memory unchanged.
//  5. Hold i_rsp_ready=0 for 3 cycles in RESP -> rsp_valid/rdata stable, o_req_ready=0;
//     release with a new valid store -> accepted on the same edge.
//  6. Assert i_rst in RD_WAIT -> outputs 0 immediately, no response. Next load returns correct data.

Source files
------------

// File: rtl/bram32_lsu_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram32_lsu_adapter: CPU load/store port to 32-bit word BRAM adapter.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bram32_lsu_adapter #(
  parameter int DEPTH = 512
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [31:0]                    i_req_addr,
  input  logic                           i_req_we,
  input  logic [1:0]                     i_req_size,
  input  logic                           i_req_unsigned,
  input  logic [31:0]                    i_req_wdata,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [31:0]                    o_rsp_rdata,
  output logic                           o_rsp_err,
  output logic [$clog2(DEPTH)-1:0]       o_mem_addr,
  output logic [31:0]                    o_mem_wdata,
  output logic                           o_mem_we,
  output logic [2:0]                     o_mem_wr_subaddr,
  input  logic [31:0]                    i_mem_rdata
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [31:0] r_rsp_rdata;
  logic [31:0] w_rsp_rdata_nxt;
  logic        r_rsp_err;
  logic        w_rsp_err_nxt;

  logic        w_accept;
  logic        w_oor;
  logic        w_err;
  logic        w_is_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  // Any address bit above the BRAM's byte range is out of range.
  generate
    if (ADDR_WIDTH + 2 < 32) begin : g_oor_chk
      assign w_oor = |i_req_addr[31:ADDR_WIDTH+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_err = (i_req_size == 2'd3)
               | ((i_req_size == 2'd1) & i_req_addr[0])
               | ((i_req_size == 2'd2) & (i_req_addr[1:0] != 2'b00))
               | w_oor;

  assign o_req_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & i_rsp_ready);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_is_load   = ~i_req_we & ~w_err;

  assign o_mem_addr  = i_req_addr[ADDR_WIDTH+1:2];
  assign o_mem_wdata = i_req_wdata;
  assign o_mem_we    = w_accept & i_req_we & ~w_err;

  always_comb begin
    o_mem_wr_subaddr = 3'd0;
    if (o_mem_we) begin
      case (i_req_size)
        2'd2:    o_mem_wr_subaddr = 3'd1;
        2'd1:    o_mem_wr_subaddr = {2'b01, i_req_addr[1]};
        2'd0:    o_mem_wr_subaddr = {1'b1, i_req_addr[1:0]};
        default: o_mem_wr_subaddr = 3'd0;
      endcase
    end
  end

  // Lane select and extension use the size/offset latched at accept time.
  assign w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_fmt = i_mem_rdata;
    case (r_size)
      2'd0:    w_load_fmt = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'd1:    w_load_fmt = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_fmt = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (w_is_load) begin
            w_state_nxt = S_RD_WAIT;
          end else begin
            w_state_nxt     = S_RESP;
            w_rsp_rdata_nxt = 32'd0;
            w_rsp_err_nxt   = w_err;
          end
        end else if ((r_state == S_RESP) & i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        w_state_nxt     = S_RESP;
        w_rsp_rdata_nxt = w_load_fmt;
        w_rsp_err_nxt   = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_off       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (w_accept & w_is_load) begin
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_off      <= i_req_addr[1:0];
      end
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_bram32_lsu_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bram32_lsu_adapter: scoreboard bench with a 512-word BRAM model.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bram32_lsu_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_sub;

  logic [31:0] mem [0:511];
  logic [32:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bram32_lsu_adapter #(.DEPTH(512)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_we(req_we), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_mem_wr_subaddr(mem_sub), .i_mem_rdata(mem_rdata)
  );

  // BRAM model: registered read, lane writes selected by subaddress.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      case (mem_sub)
        3'd1:    mem[mem_addr]        <= mem_wdata;
        3'd2:    mem[mem_addr][15:0]  <= mem_wdata[15:0];
        3'd3:    mem[mem_addr][31:16] <= mem_wdata[15:0];
        3'd4:    mem[mem_addr][7:0]   <= mem_wdata[7:0];
        3'd5:    mem[mem_addr][15:8]  <= mem_wdata[7:0];
        3'd6:    mem[mem_addr][23:16] <= mem_wdata[7:0];
        3'd7:    mem[mem_addr][31:24] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input logic push,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [2:0] exp_sub, output int waits);
    bit got = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_we = we; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    if (push) exp_q.push_back({exp_err, exp_rd});
    waits = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
      else begin
        waits++;
        @(posedge clk);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 50 cycles");
    end else begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_sub != 3'd0});
      chk("mem_subaddr", {29'd0, mem_sub}, {29'd0, exp_sub});
      chk("mem_addr", {23'd0, mem_addr}, {23'd0, addr[10:2]});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b1;
    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Word stores, then signed byte load with latency check.
    issue(32'h00, 1, 2'd2, 0, 32'h11223344, 1, 32'd0, 0, 3'd1, w);
    issue(32'h10, 1, 2'd2, 0, 32'hDEADBEEF, 1, 32'd0, 0, 3'd1, w);
    issue(32'h13, 0, 2'd0, 0, 32'd0, 1, 32'hFFFFFFDE, 0, 3'd0, w);
    @(negedge clk);
    chk("lat_edge1_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Half loads.
    issue(32'h12, 0, 2'd1, 1, 32'd0, 1, 32'h0000DEAD, 0, 3'd0, w);
    issue(32'h10, 0, 2'd1, 0, 32'd0, 1, 32'hFFFFBEEF, 0, 3'd0, w);

    // Byte store into lane 1, readback.
    issue(32'h11, 1, 2'd0, 0, 32'h0000005A, 1, 32'd0, 0, 3'd5, w);
    issue(32'h10, 0, 2'd2, 0, 32'd0, 1, 32'hDEAD5AEF, 0, 3'd0, w);
    issue(32'h11, 0, 2'd0, 1, 32'd0, 1, 32'h0000005A, 0, 3'd0, w);

    // Faulting accesses: no write, err response, memory intact.
    issue(32'h02, 1, 2'd2, 0, 32'hFFFFFFFF, 1, 32'd0, 1, 3'd0, w);
    issue(32'h800, 1, 2'd2, 0, 32'hFFFFFFFF, 1, 32'd0, 1, 3'd0, w);
    issue(32'h800, 0, 2'd2, 0, 32'd0, 1, 32'd0, 1, 3'd0, w);
    issue(32'h11, 0, 2'd1, 0, 32'd0, 1, 32'd0, 1, 3'd0, w);
    issue(32'h00, 0, 2'd3, 0, 32'd0, 1, 32'd0, 1, 3'd0, w);
    issue(32'h00, 0, 2'd2, 0, 32'd0, 1, 32'h11223344, 0, 3'd0, w);
    issue(32'h10, 0, 2'd2, 0, 32'd0, 1, 32'hDEAD5AEF, 0, 3'd0, w);

    // Response backpressure, then back-to-back store on release.
    drain();
    rsp_ready = 1'b0;
    issue(32'h10, 0, 2'd2, 0, 32'd0, 1, 32'hDEAD5AEF, 0, 3'd0, w);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hDEAD5AEF);
      chk("hold_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(32'h20, 1, 2'd2, 0, 32'hCAFEF00D, 1, 32'd0, 0, 3'd1, w);
    chk("b2b_accept_waits", w, 32'd0);
    issue(32'h20, 0, 2'd2, 0, 32'd0, 1, 32'hCAFEF00D, 0, 3'd0, w);

    // Reset while a load waits on BRAM data.
    drain();
    issue(32'h10, 0, 2'd2, 0, 32'd0, 0, 32'd0, 0, 3'd0, w);
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mid_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(32'h10, 0, 2'd2, 0, 32'd0, 1, 32'hDEAD5AEF, 0, 3'd0, w);

    drain();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
